// File: rtl/polyeval_horner_mc.sv
// polyeval_horner_mc: multi-channel, time-multiplexed polynomial evaluator.
// Horner's method on one shared signed fixed-point MAC; per-channel coefficients and order.
// Optional build macro POLYEVAL_SAT_EN: saturate overflowing steps instead of wrapping.
// Assumes WID_F <= WID_D.
module polyeval_horner_mc #(
    parameter int WID_D   = 32,
    parameter int WID_F   = 32,
    parameter int FRAC_W  = 16,
    parameter int ORD_NUM = 8,
    parameter int CH_NUM  = 4,
    parameter int CNT_W   = $clog2(ORD_NUM + 1),
    parameter int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WID_D-1:0] data_i,
    input  logic [CH_W-1:0]  ch_i,
    input  logic             data_vld_i,
    output logic             data_rdy_o,
    input  logic             coef_we,
    input  logic             ord_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] coef_idx,
    input  logic [WID_F-1:0] cfg_wdata,
    output logic             cfg_rdy_o,
    output logic [WID_D-1:0] data_cal_out,
    output logic [CH_W-1:0]  ch_o,
    output logic             ovf_o,
    output logic             data_vld_o,
    input  logic             data_rdy_i
);
    localparam int PROD_W = 2 * WID_D;
    localparam logic [CNT_W-1:0] ORD_MAX = CNT_W'(ORD_NUM);
    localparam logic [CH_W:0]    CH_LIM  = (CH_W + 1)'(CH_NUM);
    localparam logic signed [WID_D-1:0] ACC_MAX = {1'b0, {(WID_D - 1){1'b1}}};
    localparam logic signed [WID_D-1:0] ACC_MIN = {1'b1, {(WID_D - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StOut} state_t;
    state_t state_q, state_d;

    logic signed [WID_F-1:0] coef_q [CH_NUM][ORD_NUM + 1];
    logic [CNT_W-1:0]        ord_q  [CH_NUM];

    logic signed [WID_D-1:0] acc_q, x_q;
    logic [CH_W-1:0]         ch_q;
    logic                    ovf_q;
    logic [CNT_W-1:0]        cnt_q;

    logic                    ch_ok, cfg_ch_ok, accept;
    logic [CNT_W-1:0]        ord_sel, cnt_dec;
    logic signed [WID_F-1:0] coef_first, coef_step;
    logic [PROD_W-1:0]       prod;
    logic signed [PROD_W-1:0] prod_sh;
    logic signed [WID_D-1:0] prod_lo;
    logic signed [WID_D:0]   sum;
    logic                    sh_ovf, sum_ovf, step_ovf;
    logic signed [WID_D-1:0] acc_step;

    assign ch_ok      = {1'b0, ch_i} < CH_LIM;
    assign cfg_ch_ok  = {1'b0, cfg_ch} < CH_LIM;
    assign ord_sel    = ch_ok ? ord_q[ch_i] : '0;
    assign coef_first = ch_ok ? coef_q[ch_i][ord_sel] : '0;
    assign cnt_dec    = cnt_q - CNT_W'(1);
    assign coef_step  = coef_q[ch_q][cnt_dec];
    assign accept     = data_vld_i && data_rdy_o;

    // Full-precision product of sign-extended operands, then floor shift back to the Q format.
    assign prod    = {{WID_D{acc_q[WID_D-1]}}, acc_q} * {{WID_D{x_q[WID_D-1]}}, x_q};
    assign prod_sh = $signed(prod) >>> FRAC_W;
    assign prod_lo = prod_sh[WID_D-1:0];
    assign sh_ovf  = !((&prod_sh[PROD_W-1:WID_D-1]) || !(|prod_sh[PROD_W-1:WID_D-1]));
    assign sum     = (WID_D + 1)'(prod_lo) + (WID_D + 1)'(coef_step);
    assign sum_ovf = sum[WID_D] ^ sum[WID_D-1];
    assign step_ovf = sh_ovf || sum_ovf;

`ifdef POLYEVAL_SAT_EN
    // An out-of-range product dominates any coefficient, so its sign is the true result sign.
    logic sat_neg;
    assign sat_neg  = sh_ovf ? prod_sh[PROD_W-1] : sum[WID_D];
    assign acc_step = !step_ovf ? sum[WID_D-1:0] : (sat_neg ? ACC_MIN : ACC_MAX);
`else
    assign acc_step = sum[WID_D-1:0];
`endif

    assign data_cal_out = acc_q;
    assign ch_o         = ch_q;
    assign ovf_o        = ovf_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next state and handshake outputs; configuration strobes block sample acceptance.
    always_comb begin
        state_d    = state_q;
        data_rdy_o = 1'b0;
        cfg_rdy_o  = 1'b0;
        data_vld_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                cfg_rdy_o  = 1'b1;
                data_rdy_o = !coef_we && !ord_we;
                if (data_vld_i && !coef_we && !ord_we) begin
                    state_d = (!ch_ok || ord_sel == '0) ? StOut : StCalc;
                end
            end
            StCalc: begin
                if (cnt_dec == '0) state_d = StOut;
            end
            StOut: begin
                cfg_rdy_o  = 1'b1;
                data_vld_o = 1'b1;
                if (data_rdy_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: load top coefficient on accept, one Horner step per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            x_q   <= '0;
            ch_q  <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            x_q   <= data_i;
            ch_q  <= ch_i;
            ovf_q <= 1'b0;
            cnt_q <= ord_sel;
            acc_q <= WID_D'(coef_first);
        end else if (state_q == StCalc) begin
            acc_q <= acc_step;
            ovf_q <= ovf_q | step_ovf;
            cnt_q <= cnt_dec;
        end
    end

    // Coefficient and order tables; out-of-range targets are ignored, orders clamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH_NUM; c++) begin
                ord_q[c] <= ORD_MAX;
                for (int k = 0; k <= ORD_NUM; k++) coef_q[c][k] <= '0;
            end
        end else if (cfg_rdy_o && cfg_ch_ok) begin
            if (coef_we && coef_idx <= ORD_MAX) coef_q[cfg_ch][coef_idx] <= cfg_wdata;
            if (ord_we) begin
                ord_q[cfg_ch] <= (cfg_wdata[CNT_W-1:0] > ORD_MAX) ? ORD_MAX : cfg_wdata[CNT_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_polyeval_horner_mc.sv
// Self-checking bench for polyeval_horner_mc with a behavioural Horner model.
// Three channels so that an out-of-range channel id (3) is representable on ch_i.
module tb_polyeval_horner_mc;
    localparam int ORD_NUM = 8;
    localparam int CH_NUM  = 3;
    localparam int CNT_W   = 4;
    localparam int CH_W    = 2;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [31:0] data_i = '0;
    logic [CH_W-1:0] ch_i = '0;
    logic data_vld_i = 1'b0;
    logic data_rdy_o;
    logic coef_we = 1'b0;
    logic ord_we = 1'b0;
    logic [CH_W-1:0] cfg_ch = '0;
    logic [CNT_W-1:0] coef_idx = '0;
    logic [31:0] cfg_wdata = '0;
    logic cfg_rdy_o;
    logic [31:0] data_cal_out;
    logic [CH_W-1:0] ch_o;
    logic ovf_o;
    logic data_vld_o;
    logic data_rdy_i = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int m_coef [CH_NUM][ORD_NUM + 1];
    int m_ord [CH_NUM];

    polyeval_horner_mc #(
        .WID_D(32), .WID_F(32), .FRAC_W(16), .ORD_NUM(ORD_NUM), .CH_NUM(CH_NUM)
    ) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .ch_i(ch_i), .data_vld_i(data_vld_i),
        .data_rdy_o(data_rdy_o), .coef_we(coef_we), .ord_we(ord_we), .cfg_ch(cfg_ch),
        .coef_idx(coef_idx), .cfg_wdata(cfg_wdata), .cfg_rdy_o(cfg_rdy_o),
        .data_cal_out(data_cal_out), .ch_o(ch_o), .ovf_o(ovf_o), .data_vld_o(data_vld_o),
        .data_rdy_i(data_rdy_i)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < CH_NUM; c++) begin
            m_ord[c] = ORD_NUM;
            for (int k = 0; k <= ORD_NUM; k++) m_coef[c][k] = 0;
        end
    endtask

    // y = sum c[k] x^k by Horner in Q16.16, tracking range overflow per step.
    task automatic model_eval(input int ch, input int x, output int y, output bit ovf,
                              output int ord);
        longint acc, sh, s, exact;
        bit so;
        y = 0; ovf = 0; ord = 0;
        if (ch >= CH_NUM) return;
        ord = m_ord[ch];
        acc = longint'(m_coef[ch][ord]);
        for (int k = ord - 1; k >= 0; k--) begin
            sh = (acc * longint'(x)) >>> 16;
            so = (sh > MAXI) || (sh < MINI);
            s = longint'(int'(sh)) + longint'(m_coef[ch][k]);
            so = so || (s > MAXI) || (s < MINI);
            exact = sh + longint'(m_coef[ch][k]);
`ifdef POLYEVAL_SAT_EN
            if (so) acc = (exact < 0) ? MINI : MAXI;
            else acc = s;
`else
            acc = longint'(int'(s));
`endif
            ovf = ovf || so;
        end
        y = int'(acc);
    endtask

    function automatic int rand_q(input int half);
        int v;
        v = int'($urandom_range(0, 2 * half));
        return v - half;
    endfunction

    // Config helpers: called just after a falling edge while the DUT accepts writes.
    task automatic write_coef(input int ch, input int idx, input int val);
        coef_we = 1'b1; cfg_ch = CH_W'(ch); coef_idx = CNT_W'(idx); cfg_wdata = val;
        @(negedge clk);
        coef_we = 1'b0;
        if (ch < CH_NUM && idx <= ORD_NUM) m_coef[ch][idx] = val;
    endtask

    task automatic write_ord(input int ch, input int val);
        ord_we = 1'b1; cfg_ch = CH_W'(ch); cfg_wdata = val;
        @(negedge clk);
        ord_we = 1'b0;
        if (ch < CH_NUM) m_ord[ch] = (val > ORD_NUM) ? ORD_NUM : val;
    endtask

    // Present one sample, wait (bounded) for the result, then handshake it.
    task automatic run_sample(input int ch, input int x, output int y, output bit ovf,
                              output int chv, output int lat);
        int w;
        data_vld_i = 1'b1; ch_i = CH_W'(ch); data_i = x;
        #1;
        w = 0;
        while (!data_rdy_o && w < 20) begin @(negedge clk); #1; w++; end
        @(negedge clk);
        data_vld_i = 1'b0;
        lat = 1;
        while (!data_vld_o && lat < 40) begin @(negedge clk); lat++; end
        y = data_cal_out; ovf = ovf_o; chv = int'(ch_o);
        data_rdy_i = 1'b1;
        @(negedge clk);
        data_rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        int y, chv, lat, ey, eord;
        bit ovf, eovf;
        #1 rst = 1'b1;
        model_reset();
        @(negedge clk); @(negedge clk);
        n_checks++; if (data_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", data_vld_o); end
        n_checks++; if (data_cal_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_cal_out); end
        n_checks++; if (ch_o !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", ch_o); end
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
        n_checks++; if (data_rdy_o !== 1'b1 || cfg_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b/%b want 1/1", data_rdy_o, cfg_rdy_o); end
        rst = 1'b0;
        @(negedge clk);
        // Fresh tables: zero coefficients, full order.
        model_eval(1, 32'h00012345, ey, eovf, eord);
        run_sample(1, 32'h00012345, y, ovf, chv, lat);
        n_checks++; if (y !== ey) begin n_fail++; $display("FAIL reset_eval_y: got %h want %h", y, ey); end
        n_checks++; if (lat !== eord + 1) begin n_fail++; $display("FAIL reset_eval_lat: got %0d want %0d", lat, eord + 1); end
    endtask

    task automatic test_basic();
        int y, chv, lat, ey, eord;
        bit ovf, eovf;
        write_ord(0, 2);
        write_coef(0, 0, 32'h00010000);
        write_coef(0, 1, 32'h00030000);
        write_coef(0, 2, 32'h00008000);
        model_eval(0, 32'h00020000, ey, eovf, eord);
        run_sample(0, 32'h00020000, y, ovf, chv, lat);
        n_checks++; if (y !== ey) begin n_fail++; $display("FAIL basic_y: got %h want %h", y, ey); end
        n_checks++; if (ovf !== eovf) begin n_fail++; $display("FAIL basic_ovf: got %b want %b", ovf, eovf); end
        n_checks++; if (chv !== 0) begin n_fail++; $display("FAIL basic_ch: got %0d want 0", chv); end
        n_checks++; if (lat !== eord + 1) begin n_fail++; $display("FAIL basic_lat: got %0d want %0d", lat, eord + 1); end
    endtask

    task automatic test_order0();
        int y, chv, lat, ey, eord, x;
        bit ovf, eovf;
        write_ord(1, 0);
        write_coef(1, 0, 32'hFFFF0000);
        x = int'($urandom());
        model_eval(1, x, ey, eovf, eord);
        run_sample(1, x, y, ovf, chv, lat);
        n_checks++; if (y !== ey) begin n_fail++; $display("FAIL ord0_y: got %h want %h", y, ey); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ord0_lat: got %0d want 1", lat); end
        run_sample(CH_NUM, x, y, ovf, chv, lat);
        n_checks++; if (y !== 0 || ovf !== 1'b0) begin n_fail++; $display("FAIL badch_y: got %h/%b want 0/0", y, ovf); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL badch_lat: got %0d want 1", lat); end
        n_checks++; if (chv !== CH_NUM) begin n_fail++; $display("FAIL badch_ch: got %0d want %0d", chv, CH_NUM); end
    endtask

    task automatic test_overflow();
        int y, chv, lat, ey, eord;
        bit ovf, eovf;
        write_ord(2, 1);
        write_coef(2, 1, 32'h00020000);
        write_coef(2, 0, 0);
        model_eval(2, 32'h7FFF0000, ey, eovf, eord);
        run_sample(2, 32'h7FFF0000, y, ovf, chv, lat);
        n_checks++; if (y !== ey) begin n_fail++; $display("FAIL ovf_y: got %h want %h", y, ey); end
        n_checks++; if (ovf !== eovf) begin n_fail++; $display("FAIL ovf_flag: got %b want %b", ovf, eovf); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int ch, x, y, chv, lat, ey, eord, v;
            bit ovf, eovf;
            ch = int'($urandom_range(0, CH_NUM));
            if (ch < CH_NUM && $urandom_range(0, 1) == 1) begin
                write_ord(ch, int'($urandom_range(0, 15)));
                for (int k = 0; k <= ORD_NUM; k++) begin
                    v = ($urandom_range(0, 5) == 0) ? int'($urandom()) : rand_q(32'h40000);
                    write_coef(ch, k, v);
                end
            end
            x = rand_q(32'h20000);
            model_eval(ch, x, ey, eovf, eord);
            run_sample(ch, x, y, ovf, chv, lat);
            n_checks++; if (y !== ey || ovf !== eovf) begin n_fail++; $display("FAIL rand_y[%0d]: got %h/%b want %h/%b", i, y, ovf, ey, eovf); end
            n_checks++; if (lat !== eord + 1 || chv !== ch) begin n_fail++; $display("FAIL rand_lat_ch[%0d]: got %0d/%0d want %0d/%0d", i, lat, chv, eord + 1, ch); end
        end
    endtask

    task automatic test_backpressure();
        int x1, x2, ey1, ey2, eo1, eo2, lat, w;
        bit ev1, ev2;
        bit bad;
        write_ord(0, 3);
        x1 = rand_q(32'h20000); x2 = rand_q(32'h20000);
        model_eval(0, x1, ey1, ev1, eo1);
        model_eval(0, x2, ey2, ev2, eo2);
        data_vld_i = 1'b1; ch_i = '0; data_i = x1;
        #1; w = 0;
        while (!data_rdy_o && w < 20) begin @(negedge clk); #1; w++; end
        @(negedge clk);
        data_i = x2;  // second sample stays pending
        lat = 1;
        while (!data_vld_o && lat < 40) begin @(negedge clk); lat++; end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (data_vld_o !== 1'b1 || data_rdy_o !== 1'b0 || data_cal_out !== ey1
                || ovf_o !== ev1 || ch_o !== 2'd0) bad = 1;
            @(negedge clk);
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL bp_hold: got unstable (y=%h) want %h held", data_cal_out, ey1); end
        data_rdy_i = 1'b1;
        @(negedge clk);
        data_rdy_i = 1'b0;
        #1;
        n_checks++; if (data_vld_o !== 1'b0 || data_rdy_o !== 1'b1) begin n_fail++; $display("FAIL bp_release: got vld=%b rdy=%b want 0/1", data_vld_o, data_rdy_o); end
        @(negedge clk);
        data_vld_i = 1'b0;
        lat = 1;
        while (!data_vld_o && lat < 40) begin @(negedge clk); lat++; end
        n_checks++; if (data_cal_out !== ey2 || lat !== eo2 + 1) begin n_fail++; $display("FAIL bp_second: got %h lat %0d want %h lat %0d", data_cal_out, lat, ey2, eo2 + 1); end
        data_rdy_i = 1'b1;
        @(negedge clk);
        data_rdy_i = 1'b0;
    endtask

    task automatic test_priority();
        int x, y, chv, lat, ey, eord, nv, w;
        bit ovf, eovf;
        x = rand_q(32'h20000);
        nv = rand_q(32'h40000);
        data_vld_i = 1'b1; ch_i = '0; data_i = x;
        coef_we = 1'b1; cfg_ch = '0; coef_idx = '0; cfg_wdata = nv;
        #1;
        n_checks++; if (data_rdy_o !== 1'b0 || cfg_rdy_o !== 1'b1) begin n_fail++; $display("FAIL prio_rdy: got %b/%b want 0/1", data_rdy_o, cfg_rdy_o); end
        @(negedge clk);
        coef_we = 1'b0;
        m_coef[0][0] = nv;
        #1;
        n_checks++; if (data_rdy_o !== 1'b1) begin n_fail++; $display("FAIL prio_next: got %b want 1", data_rdy_o); end
        model_eval(0, x, ey, eovf, eord);
        run_sample(0, x, y, ovf, chv, lat);
        n_checks++; if (y !== ey) begin n_fail++; $display("FAIL prio_y: got %h want %h", y, ey); end

        // Writes during CALC are dropped.
        write_ord(1, 8);
        for (int k = 0; k <= ORD_NUM; k++) write_coef(1, k, rand_q(32'h20000));
        data_vld_i = 1'b1; ch_i = 2'd1; data_i = x;
        #1; w = 0;
        while (!data_rdy_o && w < 20) begin @(negedge clk); #1; w++; end
        @(negedge clk);
        data_vld_i = 1'b0;
        coef_we = 1'b1; cfg_ch = 2'd1; coef_idx = 4'd3; cfg_wdata = 32'h12340000;
        #1;
        n_checks++; if (cfg_rdy_o !== 1'b0) begin n_fail++; $display("FAIL drop_cfgrdy: got %b want 0", cfg_rdy_o); end
        @(negedge clk);
        coef_we = 1'b0;
        lat = 2;
        while (!data_vld_o && lat < 40) begin @(negedge clk); lat++; end
        data_rdy_i = 1'b1;
        @(negedge clk);
        data_rdy_i = 1'b0;
        // Out-of-range targets are ignored too.
        write_coef(CH_NUM, 0, 32'h11110000);
        write_coef(1, ORD_NUM + 1, 32'h22220000);
        model_eval(1, x, ey, eovf, eord);
        run_sample(1, x, y, ovf, chv, lat);
        n_checks++; if (y !== ey) begin n_fail++; $display("FAIL drop_readback: got %h want %h", y, ey); end

        write_ord(2, 15);
        x = rand_q(32'h10000);
        model_eval(2, x, ey, eovf, eord);
        run_sample(2, x, y, ovf, chv, lat);
        n_checks++; if (lat !== ORD_NUM + 1 || y !== ey) begin n_fail++; $display("FAIL clamp: got lat %0d y %h want lat %0d y %h", lat, y, ORD_NUM + 1, ey); end
    endtask

    task automatic test_reset_mid();
        int x, y, chv, lat, ey, eord, w;
        bit ovf, eovf, seen;
        write_ord(0, 8);
        for (int k = 0; k <= ORD_NUM; k++) write_coef(0, k, rand_q(32'h20000) | 32'h100);
        data_vld_i = 1'b1; ch_i = '0; data_i = 32'h00018000;
        #1; w = 0;
        while (!data_rdy_o && w < 20) begin @(negedge clk); #1; w++; end
        @(negedge clk);
        data_vld_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (data_vld_o !== 1'b0 || data_cal_out !== 32'h0 || ovf_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_out: got vld=%b y=%h ovf=%b want 0", data_vld_o, data_cal_out, ovf_o); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (data_vld_o !== 1'b0) seen = 1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL rstmid_stale: got vld=1 want 0"); end
        x = rand_q(32'h20000);
        model_eval(0, x, ey, eovf, eord);
        run_sample(0, x, y, ovf, chv, lat);
        n_checks++; if (y !== ey || lat !== eord + 1) begin n_fail++; $display("FAIL rstmid_eval: got %h lat %0d want %h lat %0d", y, lat, ey, eord + 1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order0();
        test_overflow();
        test_random();
        test_backpressure();
        test_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
